// File: rtl/win_tile_gen.sv
// win_tile_gen
// Turns a scalar sample stream into overlapping TILE-sample windows for the
// Winograd F(6,3) 1D core. Consecutive windows in a row advance by STEP
// samples, so the last TILE-STEP samples of one tile open the next one.
// A sample flagged with in_last closes the row: the partial window is
// zero-padded and emitted, and the next row starts from an empty buffer.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   sample strobe (no backpressure)
//   in_data    signed sample
//   in_last    last sample of the row (qualified by in_valid)
//   tile_valid one-cycle pulse, tile_* fields valid
//   tile_D     packed tile, oldest sample in the top DW bits
//   tile_nout  number of meaningful core outputs (0..6)
//   tile_last  tile closes its row
//   tile_idx   tile number within the row
module win_tile_gen #(
  parameter int DW   = 10,
  parameter int TILE = 8,
  parameter int STEP = 6,
  parameter int IDXW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_last,
  output logic                 tile_valid,
  output logic [TILE*DW-1:0]   tile_D,
  output logic [2:0]           tile_nout,
  output logic                 tile_last,
  output logic [IDXW-1:0]      tile_idx
);

  localparam int OVL = TILE - STEP;

  logic [DW-1:0]      buf_q [TILE];
  logic [DW-1:0]      buf_d [TILE];
  logic [DW-1:0]      win   [TILE];
  logic [3:0]         fill_q, fill_d, fill_nx;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               emit;
  logic [2:0]         nout_d;
  logic [TILE*DW-1:0] flat_d;

  logic               tile_valid_q;
  logic [TILE*DW-1:0] tile_D_q;
  logic [2:0]         tile_nout_q;
  logic               tile_last_q;
  logic [IDXW-1:0]    tile_idx_q;

  always_comb begin
    fill_nx = fill_q + 4'd1;
    fill_d  = fill_q;
    idx_d   = idx_q;
    emit    = 1'b0;
    nout_d  = 3'(STEP);
    flat_d  = '0;
    for (int i = 0; i < TILE; i++) begin
      buf_d[i] = buf_q[i];
      // Window as it looks with the incoming sample written in place; on a
      // row end everything past the new sample is forced to zero so stale
      // buffer contents never leak into a padded tile.
      win[i] = (4'(i) == fill_q) ? in_data : buf_q[i];
      if (in_last && (4'(i) >= fill_nx)) win[i] = '0;
      flat_d[(TILE-1-i)*DW +: DW] = win[i];
    end

    if (in_last && (fill_nx < 4'(TILE)))
      nout_d = (fill_nx >= 4'(OVL)) ? 3'(fill_nx - 4'(OVL)) : 3'd0;

    if (in_valid) begin
      if (in_last) begin
        emit   = 1'b1;
        fill_d = 4'd0;
        idx_d  = '0;
        for (int i = 0; i < TILE; i++) buf_d[i] = '0;
      end else if (fill_nx == 4'(TILE)) begin
        emit   = 1'b1;
        fill_d = 4'(OVL);
        idx_d  = idx_q + 1'b1;
        // Compaction: the filter halo becomes the head of the next tile.
        for (int i = 0; i < OVL; i++) buf_d[i] = win[STEP+i];
      end else begin
        fill_d = fill_nx;
        for (int i = 0; i < TILE; i++) buf_d[i] = win[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TILE; i++) buf_q[i] <= '0;
      fill_q       <= 4'd0;
      idx_q        <= '0;
      tile_valid_q <= 1'b0;
      tile_D_q     <= '0;
      tile_nout_q  <= 3'd0;
      tile_last_q  <= 1'b0;
      tile_idx_q   <= '0;
    end else begin
      for (int i = 0; i < TILE; i++) buf_q[i] <= buf_d[i];
      fill_q       <= fill_d;
      idx_q        <= idx_d;
      tile_valid_q <= emit;
      if (emit) begin
        tile_D_q    <= flat_d;
        tile_nout_q <= nout_d;
        tile_last_q <= in_last;
        tile_idx_q  <= idx_q;
      end
    end
  end

  assign tile_valid = tile_valid_q;
  assign tile_D     = tile_D_q;
  assign tile_nout  = tile_nout_q;
  assign tile_last  = tile_last_q;
  assign tile_idx   = tile_idx_q;

endmodule

// File: tb/tb_win_tile_gen.sv
module tb_win_tile_gen;

  localparam int DW = 10, TILE = 8, IDXW = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic [DW-1:0]       in_data = '0;
  logic                in_last = 1'b0;
  logic                tile_valid;
  logic [TILE*DW-1:0]  tile_D;
  logic [2:0]          tile_nout;
  logic                tile_last;
  logic [IDXW-1:0]     tile_idx;

  int total = 0;
  int bad   = 0;

  win_tile_gen #(.DW(DW), .TILE(TILE), .STEP(6), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .tile_valid(tile_valid), .tile_D(tile_D),
    .tile_nout(tile_nout), .tile_last(tile_last), .tile_idx(tile_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [TILE*DW-1:0] pk(input int s0, s1, s2, s3, s4, s5, s6, s7);
    logic [DW-1:0] f [8];
    logic [TILE*DW-1:0] r;
    f[0] = DW'(s0); f[1] = DW'(s1); f[2] = DW'(s2); f[3] = DW'(s3);
    f[4] = DW'(s4); f[5] = DW'(s5); f[6] = DW'(s6); f[7] = DW'(s7);
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[TILE*DW-DW-1:0], f[i]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one input cycle; returns just after the accepting edge.
  task automatic drive(input logic v, input int d, input logic l);
    @(negedge clk);
    in_valid = v;
    in_data  = DW'(d);
    in_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag, input int d);
    drive(1'b1, d, 1'b0);
    chk(tag, 128'(tile_valid), 128'(0));
  endtask

  task automatic chk_tile(input string tag, input logic [TILE*DW-1:0] d, input int nout,
                          input logic last, input int idx);
    chk({tag, ".valid"}, 128'(tile_valid), 128'(1));
    chk({tag, ".D"},     128'(tile_D),     128'(d));
    chk({tag, ".nout"},  128'(tile_nout),  128'(nout));
    chk({tag, ".last"},  128'(tile_last),  128'(last));
    chk({tag, ".idx"},   128'(tile_idx),   128'(idx));
  endtask

  logic [TILE*DW-1:0] t0, t1;

  initial begin
    t0 = pk(2, -10, 3, 4, -13, -18, -16, -28);
    t1 = pk(-16, -28, -19, -6, 3, -9, -12, 11);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 128'(tile_valid), 128'(0));
    chk("rst.D",     128'(tile_D),     128'(0));
    chk("rst.idx",   128'(tile_idx),   128'(0));
    @(negedge clk);
    rst = 1'b0;

    // First tile
    quiet("t0.s0", 2);  quiet("t0.s1", -10); quiet("t0.s2", 3);  quiet("t0.s3", 4);
    quiet("t0.s4", -13); quiet("t0.s5", -18); quiet("t0.s6", -16);
    drive(1'b1, -28, 1'b0);
    chk_tile("t0", t0, 6, 1'b0, 0);

    // Overlap tile
    quiet("t1.s0", -19); quiet("t1.s1", -6); quiet("t1.s2", 3);
    quiet("t1.s3", -9);  quiet("t1.s4", -12);
    drive(1'b1, 11, 1'b0);
    chk_tile("t1", t1, 6, 1'b0, 1);

    // Idle cycle: pulse drops, fields hold
    drive(1'b0, 99, 1'b1);
    chk("idle.valid", 128'(tile_valid), 128'(0));
    chk("idle.D",     128'(tile_D),     128'(t1));
    chk("idle.idx",   128'(tile_idx),   128'(1));

    // Reset mid-stream between edges
    for (int i = 0; i < 5; i++) quiet("pre_rst", 100 + i);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", 128'(tile_valid), 128'(0));
    chk("arst.D",     128'(tile_D),     128'(0));
    chk("arst.nout",  128'(tile_nout),  128'(0));
    chk("arst.idx",   128'(tile_idx),   128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b0;

    // Gapped stream of the first tile after reset
    begin
      int s[8];
      s = '{2, -10, 3, 4, -13, -18, -16, -28};
      for (int i = 0; i < 8; i++) begin
        drive(1'b0, 77, 1'b0);
        chk("gap.idle", 128'(tile_valid), 128'(0));
        drive(1'b1, s[i], 1'b0);
        if (i < 7) chk("gap.acc", 128'(tile_valid), 128'(0));
      end
    end
    chk_tile("gap", t0, 6, 1'b0, 0);
    drive(1'b0, 0, 1'b0);
    chk("gap.hold.valid", 128'(tile_valid), 128'(0));
    chk("gap.hold.D",     128'(tile_D),     128'(t0));

    // Partial row end
    quiet("pr.s0", 5); quiet("pr.s1", 6);
    drive(1'b1, 7, 1'b1);
    chk_tile("prow", pk(-16, -28, 5, 6, 7, 0, 0, 0), 3, 1'b1, 1);

    // Tiny row
    drive(1'b1, 9, 1'b1);
    chk_tile("tiny", pk(9, 0, 0, 0, 0, 0, 0, 0), 0, 1'b1, 0);

    // Two-sample row
    quiet("two.s0", -1);
    drive(1'b1, -2, 1'b1);
    chk_tile("two", pk(-1, -2, 0, 0, 0, 0, 0, 0), 0, 1'b1, 0);

    // Row ending exactly on a full tile
    for (int i = 0; i < 7; i++) quiet("full_last", 20 + i);
    drive(1'b1, 27, 1'b1);
    chk_tile("fl", pk(20, 21, 22, 23, 24, 25, 26, 27), 6, 1'b1, 0);

    // No halo carries into the next row
    quiet("nr.s0", 30); quiet("nr.s1", 31);
    drive(1'b1, 32, 1'b1);
    chk_tile("nr", pk(30, 31, 32, 0, 0, 0, 0, 0), 1, 1'b1, 0);

    drive(1'b0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
